seq_arith_left_shift_sat: RTL and testbench
===========================================

Name: seq_arith_left_shift_sat

Overview:
- Multi-cycle signed multiply by a power of two: y = a * 2^s, done as an arithmetic left shift by a run-time amount s.
- This is the inverse of the signed divide-by-2^S right shifter in the combinational arithmetic set.
- Shifts one bit per clock and detects signed overflow; on overflow the result saturates to the most-positive or most-negative value.
- Valid/ready handshake on both sides, so it can sit in a streaming datapath between a producer and a consumer.

Parameters:
- N, 8, data width in bits (two's complement, N >= 2).
- SW, 4, shift-amount width in bits; legal s range is 0 .. 2^SW-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- up_valid  input  1  input operand valid.
- up_ready  output  1  block can accept an operand.
- a  input  N  signed operand.
- s  input  SW  unsigned shift amount.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- res  output  N  signed result (shifted value or saturated value).
- res_ovf  output  1  result was saturated due to signed overflow.

Behaviour:
- States: IDLE, SHIFT, DONE. Internal registers: acc[N-1:0], cnt[SW-1:0], ovf, sign0.
- Reset (rst_n low at a rising edge):
  - state = IDLE; acc, cnt, ovf = 0.
  - Any in-flight operation is discarded without output.
  - up_ready is 0 while rst_n is low.
- up_ready = rst_n && state==IDLE. res_valid = (state==DONE).
- res and res_ovf are 0 whenever res_valid = 0.
- In DONE: res = ovf ? (sign0 ? {1,0...0} : {0,1...1}) : acc. res_ovf = ovf.
- IDLE:
  - On up_valid && up_ready: load acc=a, cnt=s, ovf=0, sign0=a[N-1].
  - Next state is DONE if s==0, otherwise SHIFT.
  - Without up_valid, stay in IDLE.
- SHIFT, each cycle:
  - If acc[N-1] != acc[N-2]: set ovf=1 and go to DONE. acc is unchanged; the shift is not performed.
  - Otherwise: acc = acc<<1 (zero fill), cnt = cnt-1. If cnt==1 (before decrement), go to DONE.
- DONE:
  - res and res_ovf are registered and stay stable while res_ready is low.
  - On res_ready, the result transfers and the block returns to IDLE.
  - up_valid is ignored throughout DONE (up_ready = 0).
- Latency, counted from the accepting edge to the first cycle with res_valid high:
  - s==0: 1 cycle.
  - No overflow: s+1 cycles.
  - Overflow detected on the j-th shift attempt: j+1 cycles.
- Throughput: at most one operand per (latency + 1) cycles. There is no overlap; up_ready rises the cycle after the result handshake.
- Boundary cases:
  - a==0 never overflows, for any s.
  - s >= N with any nonzero a always overflows.
  - a = most-negative value with s >= 1 overflows immediately.
- up_valid, a and s are sampled only on the accepting edge. Changes at other times have no effect.

Test Plan:
- N=8. a=0x05, s=3 -> res=0x28, res_ovf=0, res_valid first high 4 cycles after accept.
- a=0xFB (-5), s=4 -> res=0xB0 (-80), ovf=0, latency 5. a=0xFF, s=7 -> res=0x80, ovf=0. a=0xFF, s=8 -> res=0x80, ovf=1.
- a=0x30, s=2 -> overflow on 2nd attempt: res=0x7F, ovf=1, latency 3. a=0x80, s=1 -> res=0x80, ovf=1, latency 2.
- a=0x80, s=0 -> res=0x80, ovf=0, latency 1. a=0x00, s=15 -> res=0x00, ovf=0, latency 16.
- Backpressure on a=0x05, s=3:
  - Hold res_ready=0 for 5 cycles in DONE -> res=0x28 stays stable and up_ready=0.
  - A new up_valid with a=0x11 is ignored.
  - Raise res_ready -> one transfer, then up_ready=1 on the next cycle.
- Reset mid-operation:
  - Accept a=0x01, s=6, then drive rst_n low in the 3rd SHIFT cycle.
  - Required: the next cycle is IDLE with res_valid=0, and no result is ever emitted.
  - A subsequent a=0x03, s=1 -> res=0x06 at latency 2.

Source files
------------

// File: rtl/seq_arith_left_shift_sat.sv
// Sequential signed multiply by 2^s: arithmetic left shift one bit per clock,
// saturating to the most-positive/most-negative value on signed overflow.
module seq_arith_left_shift_sat #(
  parameter int N  = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] s,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res,
  output logic          res_ovf
);

  localparam logic [1:0]    IDLE    = 2'd0;
  localparam logic [1:0]    SHIFT   = 2'd1;
  localparam logic [1:0]    DONE    = 2'd2;
  localparam logic [SW-1:0] CNT_ONE = {{(SW-1){1'b0}}, 1'b1};

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          sign0_q, sign0_d;
  logic [N-1:0]  res_q, res_d;
  logic          res_ovf_q, res_ovf_d;

  // Saturated value keeps the original operand's sign.
  function automatic logic [N-1:0] sat_value(input logic ovf, input logic sign,
                                             input logic [N-1:0] acc);
    logic [N-1:0] v;
    if (ovf) begin
      v        = {N{~sign}};
      v[N-1]   = sign;
    end else begin
      v        = acc;
    end
    return v;
  endfunction

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sign0_d = sign0_q;
    case (state_q)
      IDLE: begin
        if (up_valid) begin
          acc_d   = a;
          cnt_d   = s;
          ovf_d   = 1'b0;
          sign0_d = a[N-1];
          state_d = (s == {SW{1'b0}}) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // A differing top bit pair means the next shift would change the sign.
        if (acc_q[N-1] != acc_q[N-2]) begin
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          acc_d   = {acc_q[N-2:0], 1'b0};
          cnt_d   = cnt_q - CNT_ONE;
          state_d = (cnt_q == CNT_ONE) ? DONE : SHIFT;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result registers are zero outside DONE and hold steady while in DONE.
  always_comb begin
    res_d     = {N{1'b0}};
    res_ovf_d = 1'b0;
    if (state_d == DONE) begin
      res_d     = sat_value(ovf_d, sign0_d, acc_d);
      res_ovf_d = ovf_d;
    end else begin
      res_d     = {N{1'b0}};
      res_ovf_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= {N{1'b0}};
      cnt_q     <= {SW{1'b0}};
      ovf_q     <= 1'b0;
      sign0_q   <= 1'b0;
      res_q     <= {N{1'b0}};
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sign0_q   <= sign0_d;
      res_q     <= res_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign up_ready  = rst_n && (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign res       = res_q;
  assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_seq_arith_left_shift_sat.sv
// Self-checking bench for seq_arith_left_shift_sat: directed vectors,
// randomized operands against an arithmetic reference, backpressure and reset.
module tb_seq_arith_left_shift_sat;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up_valid;
  logic       up_ready;
  logic [7:0] a;
  logic [3:0] s;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res;
  logic       res_ovf;

  int errors = 0;
  int checks = 0;

  seq_arith_left_shift_sat #(.N(8), .SW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready), .a(a), .s(s),
    .res_valid(res_valid), .res_ready(res_ready), .res(res), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  // Reference: multiply by 2 repeatedly, overflow at the first out-of-range product.
  task automatic model(input logic [7:0] ma, input logic [3:0] ms,
                       output logic [7:0] er, output logic eo, output int el);
    int  v;
    bit  hit;
    v   = int'($signed(ma));
    hit = 1'b0;
    eo  = 1'b0;
    el  = int'(ms) + 1;
    er  = ma;
    for (int j = 1; j <= int'(ms); j++) begin
      if (!hit) begin
        v = v * 2;
        if (v > 127 || v < -128) begin
          hit = 1'b1;
          eo  = 1'b1;
          el  = j + 1;
          er  = ma[7] ? 8'h80 : 8'h7F;
        end
      end
    end
    if (!hit) er = 8'(v);
  endtask

  // Drive one operand, wait (bounded) for the result, then accept it.
  task automatic do_op(input logic [7:0] op_a, input logic [3:0] op_s,
                       output logic [7:0] o_res, output logic o_ovf,
                       output int o_lat, output int o_leak);
    o_leak = 0;
    @(negedge clk);
    up_valid = 1'b1; a = op_a; s = op_s;
    @(negedge clk);
    up_valid = 1'b0; a = 8'($urandom); s = 4'($urandom);
    o_lat = 1;
    while (!res_valid && o_lat < 40) begin
      if (res !== 8'h00 || res_ovf !== 1'b0) o_leak++;
      @(negedge clk);
      o_lat++;
    end
    o_res = res;
    o_ovf = res_ovf;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (up_ready !== 1'b0) begin $display("FAIL reset_up_ready got %b want 0", up_ready); errors++; end
    checks++;
    if (res_valid !== 1'b0 || res !== 8'h00 || res_ovf !== 1'b0) begin
      $display("FAIL reset_outputs got valid=%b res=%h ovf=%b want 0/00/0", res_valid, res, res_ovf); errors++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (up_ready !== 1'b1) begin $display("FAIL reset_release_up_ready got %b want 1", up_ready); errors++; end
  endtask

  task automatic test_vectors();
    logic [7:0] va [9] = '{8'h05, 8'hFB, 8'hFF, 8'hFF, 8'h30, 8'h80, 8'h80, 8'h00, 8'h01};
    logic [3:0] vs [9] = '{4'd3, 4'd4, 4'd7, 4'd8, 4'd2, 4'd1, 4'd0, 4'd15, 4'd8};
    logic [7:0] vr [9] = '{8'h28, 8'hB0, 8'h80, 8'h80, 8'h7F, 8'h80, 8'h80, 8'h00, 8'h7F};
    logic       vo [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int         vl [9] = '{4, 5, 8, 9, 3, 2, 1, 16, 8};
    logic [7:0] r;
    logic       o;
    int         lat, leak;
    for (int i = 0; i < 9; i++) begin
      do_op(va[i], vs[i], r, o, lat, leak);
      checks++;
      if (r !== vr[i]) begin $display("FAIL vec%0d_res got %h want %h", i, r, vr[i]); errors++; end
      checks++;
      if (o !== vo[i]) begin $display("FAIL vec%0d_ovf got %b want %b", i, o, vo[i]); errors++; end
      checks++;
      if (lat != vl[i]) begin $display("FAIL vec%0d_latency got %0d want %0d", i, lat, vl[i]); errors++; end
      checks++;
      if (leak != 0) begin $display("FAIL vec%0d_idle_outputs nonzero in %0d cycles want 0", i, leak); errors++; end
    end
  endtask

  task automatic test_random();
    logic [7:0] ra, r, er;
    logic [3:0] rs;
    logic       o, eo;
    int         lat, el, leak;
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rs = 4'($urandom);
      if (i % 7 == 0) ra = 8'h00;
      model(ra, rs, er, eo, el);
      do_op(ra, rs, r, o, lat, leak);
      checks++;
      if (r !== er || o !== eo || lat != el || leak != 0) begin
        $display("FAIL rand%0d a=%h s=%0d got res=%h ovf=%b lat=%0d leak=%0d want res=%h ovf=%b lat=%0d leak=0",
                 i, ra, rs, r, o, lat, leak, er, eo, el);
        errors++;
      end
    end
  endtask

  task automatic test_backpressure();
    int wait_cyc;
    @(negedge clk);
    up_valid = 1'b1; a = 8'h05; s = 4'd3;
    @(negedge clk);
    up_valid = 1'b0;
    wait_cyc = 1;
    while (!res_valid && wait_cyc < 40) begin @(negedge clk); wait_cyc++; end
    checks++;
    if (wait_cyc != 4) begin $display("FAIL bp_latency got %0d want 4", wait_cyc); errors++; end
    up_valid = 1'b1; a = 8'h11; s = 4'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res !== 8'h28 || res_ovf !== 1'b0 || up_ready !== 1'b0) begin
        $display("FAIL bp_hold%0d got valid=%b res=%h ovf=%b up_ready=%b want 1/28/0/0",
                 k, res_valid, res, res_ovf, up_ready);
        errors++;
      end
    end
    up_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || up_ready !== 1'b1) begin
      $display("FAIL bp_after_transfer got valid=%b up_ready=%b want 0/1", res_valid, up_ready); errors++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin $display("FAIL bp_no_ghost_op got valid=%b want 0", res_valid); errors++; end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] r;
    logic       o;
    int         lat, leak, seen;
    @(negedge clk);
    up_valid = 1'b1; a = 8'h01; s = 4'd6;
    @(negedge clk);
    up_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (up_ready !== 1'b0) begin $display("FAIL midrst_up_ready got %b want 0", up_ready); errors++; end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0 || up_ready !== 1'b1) begin
      $display("FAIL midrst_idle got valid=%b up_ready=%b want 0/1", res_valid, up_ready); errors++;
    end
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin $display("FAIL midrst_no_result got %0d valid cycles want 0", seen); errors++; end
    do_op(8'h03, 4'd1, r, o, lat, leak);
    checks++;
    if (r !== 8'h06 || o !== 1'b0 || lat != 2) begin
      $display("FAIL midrst_next_op got res=%h ovf=%b lat=%0d want 06/0/2", r, o, lat); errors++;
    end
  endtask

  initial begin
    rst_n = 1'b0; up_valid = 1'b0; res_ready = 1'b0; a = 8'h00; s = 4'd0;
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
